mole_game_core: RTL and testbench
=================================

// Module: mole_game_core
// PURPOSE
//  Parametrised whack-a-mole game engine: up to MAX_MOLES simultaneous moles on a GRID-cell
//  board, each with its own lifetime; BCD hit score; game-over on external time-up.
//  Sits between LFSR/keypad/timer (inputs) and the LCD mole decoder and 7-seg (outputs).
//  Generalises the single-mole engine: multi-mole, timed expiry, miss count, start/over FSM.
// PARAMETERS
//  GRID         16  board cells; power of two, 4..64
//  MAX_MOLES     3  concurrent mole slots, 1..8
//  LIFE_TICKS    8  tick_en pulses a mole stays up before expiring, 1..255
//  SPAWN_TICKS   3  tick_en pulses between spawn attempts, 1..255
//  SCORE_DIGITS  2  BCD digits of score and miss counters
// PORTS
//  clk        in   1                 system clock
//  rst_n      in   1                 asynchronous active-low reset
//  tick_en    in   1                 game-time strobe, one clk wide
//  start      in   1                 one-pulse start request
//  time_up    in   1                 level from countdown timer; ends game
//  rnd        in   8                 pseudo-random value, sampled on spawn attempt
//  hit_valid  in   1                 one-pulse key press
//  hit_pos    in   $clog2(GRID)      pressed cell index
//  mole_map   out  GRID              bit i = mole visible in cell i
//  score_bcd  out  4*SCORE_DIGITS    hit count, BCD
//  miss_bcd   out  4*SCORE_DIGITS    expired-mole count, BCD
//  active_cnt out  $clog2(MAX_MOLES+1) moles currently up
//  game_over  out  1                 high in OVER state
// BEHAVIOUR
//  - Reset: state IDLE; all slots empty; mole_map=0, score_bcd=0, miss_bcd=0, active_cnt=0,
//    game_over=0; spawn and life counters 0. Reset mid-game aborts immediately, same values.
//  - FSM: IDLE -start-> PLAY (score/miss/slots cleared). PLAY -time_up-> OVER. OVER -start-> PLAY
//    (counters cleared). time_up has priority over start. All outputs registered.
//  - Spawn: in PLAY, spawn counter counts tick_en; at SPAWN_TICKS it reloads and attempts spawn
//    at pos=rnd[$clog2(GRID)-1:0] into lowest-index free slot. No spawn if no slot free or cell
//    occupied (attempt lost, not retried). New slot lifetime = LIFE_TICKS.
//  - Expiry: each tick_en decrements every active slot's lifetime; at 0 slot frees, miss +1.
//  - Hit: hit_valid in PLAY with hit_pos matching an active slot frees that slot, score +1;
//    mole_map/score change visible the cycle after hit_valid (latency 1). Hit on empty cell:
//    no effect (see CONFIGURATION). hit_valid outside PLAY ignored.
//  - Same-cycle events: hit beats expiry for that slot (counts as hit, not miss); hit on a cell
//    beats spawn into same cell (spawn suppressed, attempt lost); spawn may reuse a slot freed by
//    expiry in the same cycle only on the next attempt (not same cycle).
//  - Arithmetic: BCD increment per digit with carry; saturates at all-9s (99 for 2 digits).
//  - OVER: mole_map cleared, score/miss held, lifetimes frozen.
// CONFIGURATION
//  MISS_PENALTY_EN defined: hit_valid in PLAY on an empty cell decrements score_bcd by 1,
//    saturating at 0; same latency as a hit.
//  Not defined: empty-cell presses ignored; score never decreases.
// STRUCTURE
//  - mole_pkg: state enum (IDLE/PLAY/OVER), bcd_inc / bcd_dec functions, width localparams.
//  - Sub-module mole_slot: one per slot (generate); holds active, pos, lifetime; inputs
//    load/pos, tick, hit_clr; outputs active, pos, expire pulse. Core does arbitration.
// TESTING
//  1 Reset mid-PLAY with 2 moles up -> next cycle mole_map=0, score=0, state IDLE.
//  2 start, rnd=5 at first spawn attempt, hit_pos=5 next cycle -> mole_map[5] 1 then 0, score=01.
//  3 No hits, LIFE_TICKS=8 -> mole clears exactly on 8th tick_en after spawn, miss_bcd=01.
//  4 3 slots full, 4th attempt rnd=9 -> no spawn, active_cnt stays 3; rnd hitting occupied cell
//    -> no spawn.
//  5 hit_valid same cycle as expiry of that mole -> score+1, miss unchanged; 99 hits -> score
//    stays 99.
//  6 MISS_PENALTY_EN: score=00, press empty -> 00; score=03, press empty -> 02; without macro -> 03.

Source files
------------

// File: rtl/mole_game_core_pkg.sv
// Shared types and BCD helpers for the whack-a-mole engine.
package mole_pkg;
    localparam int BCD_MAX_DIGITS = 8;
    localparam int BCD_W          = 4 * BCD_MAX_DIGITS;
    localparam int LIFE_W         = 8;

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    // Increment the low 'digits' BCD digits, holding at all-9s.
    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v, input int digits);
        logic [BCD_W-1:0] r;
        logic carry;
        logic sat;
        r     = v;
        carry = 1'b1;
        sat   = 1'b1;
        for (int d = 0; d < BCD_MAX_DIGITS; d++)
            if (d < digits && v[4*d +: 4] != 4'd9) sat = 1'b0;
        for (int d = 0; d < BCD_MAX_DIGITS; d++) begin
            if (d < digits && carry && !sat) begin
                if (r[4*d +: 4] == 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = r[4*d +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Decrement the low 'digits' BCD digits, holding at zero.
    function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] v, input int digits);
        logic [BCD_W-1:0] r;
        logic borrow;
        logic zero;
        r      = v;
        borrow = 1'b1;
        zero   = 1'b1;
        for (int d = 0; d < BCD_MAX_DIGITS; d++)
            if (d < digits && v[4*d +: 4] != 4'd0) zero = 1'b0;
        for (int d = 0; d < BCD_MAX_DIGITS; d++) begin
            if (d < digits && borrow && !zero) begin
                if (r[4*d +: 4] == 4'd0) begin
                    r[4*d +: 4] = 4'd9;
                end else begin
                    r[4*d +: 4] = r[4*d +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/mole_game_core_slot.sv
// One mole slot: occupancy, cell position and remaining lifetime.
module mole_slot
    import mole_pkg::*;
#(
    parameter int POS_W      = 4,
    parameter int LIFE_TICKS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [POS_W-1:0] load_pos,
    input  logic             tick,
    input  logic             hit_clr,
    output logic             active,
    output logic [POS_W-1:0] pos,
    output logic             expire
);
    logic [LIFE_W-1:0] life;

    // A hit in the same cycle wins over expiry.
    assign expire = active && tick && !hit_clr && (life == LIFE_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            pos    <= '0;
            life   <= '0;
        end else if (clr) begin
            active <= 1'b0;
            life   <= '0;
        end else if (load) begin
            active <= 1'b1;
            pos    <= load_pos;
            life   <= LIFE_W'(LIFE_TICKS);
        end else if (hit_clr || expire) begin
            active <= 1'b0;
            life   <= '0;
        end else if (active && tick) begin
            life <= life - LIFE_W'(1);
        end
    end
endmodule

// File: rtl/mole_game_core.sv
// Multi-mole whack-a-mole engine with BCD score/miss counters.
// Optional MISS_PENALTY_EN: pressing an empty cell during play costs one point.
module mole_game_core
    import mole_pkg::*;
#(
    parameter int GRID         = 16,
    parameter int MAX_MOLES    = 3,
    parameter int LIFE_TICKS   = 8,
    parameter int SPAWN_TICKS  = 3,
    parameter int SCORE_DIGITS = 2,
    localparam int POS_W       = $clog2(GRID),
    localparam int CNT_W       = $clog2(MAX_MOLES + 1),
    localparam int SW          = 4 * SCORE_DIGITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_en,
    input  logic             start,
    input  logic             time_up,
    input  logic [7:0]       rnd,
    input  logic             hit_valid,
    input  logic [POS_W-1:0] hit_pos,
    output logic [GRID-1:0]  mole_map,
    output logic [SW-1:0]    score_bcd,
    output logic [SW-1:0]    miss_bcd,
    output logic [CNT_W-1:0] active_cnt,
    output logic             game_over
);
    state_t state, state_nx;
    logic [LIFE_W-1:0] spawn_cnt;
    logic [SW-1:0] score, miss, score_nx, miss_nx;
    logic [MAX_MOLES-1:0] slot_act, slot_exp, hit_clr, load;
    logic [MAX_MOLES-1:0][POS_W-1:0] slot_pos;
    logic [GRID-1:0] map;
    logic [CNT_W-1:0] cnt;
    logic [POS_W-1:0] rpos;
    logic play_go, tick, press, attempt, game_start, any_hit, occupied, taken, spawn_ok;
    logic [BCD_W-1:0] s_ext, m_ext;
    logic unused_rnd;

    assign unused_rnd = ^rnd;
    assign rpos       = rnd[POS_W-1:0];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, OVER: if (start && !time_up) state_nx = PLAY;
            PLAY:       if (time_up) state_nx = OVER;
            default:    state_nx = IDLE;
        endcase
    end

    // Nothing happens on the cycle that ends the game.
    assign play_go    = (state == PLAY) && !time_up;
    assign tick       = play_go && tick_en;
    assign press      = play_go && hit_valid;
    assign attempt    = tick && (spawn_cnt == LIFE_W'(SPAWN_TICKS - 1));
    assign game_start = (state != PLAY) && (state_nx == PLAY);

    always_comb begin
        hit_clr  = '0;
        load     = '0;
        map      = '0;
        cnt      = '0;
        occupied = 1'b0;
        taken    = 1'b0;
        for (int i = 0; i < MAX_MOLES; i++) begin
            hit_clr[i] = press && slot_act[i] && (slot_pos[i] == hit_pos);
            if (slot_act[i]) begin
                map[slot_pos[i]] = 1'b1;
                cnt              = cnt + CNT_W'(1);
                if (slot_pos[i] == rpos) occupied = 1'b1;
            end
        end
        any_hit  = |hit_clr;
        spawn_ok = attempt && !occupied && !(press && (hit_pos == rpos));
        // Slots freeing this cycle still look busy, so reuse waits for the next attempt.
        for (int i = 0; i < MAX_MOLES; i++) begin
            if (spawn_ok && !slot_act[i] && !taken) begin
                load[i] = 1'b1;
                taken   = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < MAX_MOLES; i++) begin : g_slot
        mole_slot #(.POS_W(POS_W), .LIFE_TICKS(LIFE_TICKS)) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (state_nx != PLAY),
            .load     (load[i]),
            .load_pos (rpos),
            .tick     (tick),
            .hit_clr  (hit_clr[i]),
            .active   (slot_act[i]),
            .pos      (slot_pos[i]),
            .expire   (slot_exp[i])
        );
    end

    always_comb begin
        s_ext = BCD_W'(score);
        if (any_hit) s_ext = bcd_inc(s_ext, SCORE_DIGITS);
`ifdef MISS_PENALTY_EN
        else if (press) s_ext = bcd_dec(s_ext, SCORE_DIGITS);
`endif
        score_nx = s_ext[SW-1:0];
        m_ext = BCD_W'(miss);
        for (int i = 0; i < MAX_MOLES; i++)
            if (slot_exp[i]) m_ext = bcd_inc(m_ext, SCORE_DIGITS);
        miss_nx = m_ext[SW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            score     <= '0;
            miss      <= '0;
            spawn_cnt <= '0;
        end else begin
            state <= state_nx;
            if (game_start) begin
                score     <= '0;
                miss      <= '0;
                spawn_cnt <= '0;
            end else begin
                score <= score_nx;
                miss  <= miss_nx;
                if (tick) spawn_cnt <= attempt ? '0 : spawn_cnt + LIFE_W'(1);
            end
        end
    end

    // Board view is a pure decode of slot flops; slots are held empty outside PLAY.
    assign mole_map   = map;
    assign active_cnt = cnt;
    assign score_bcd  = score;
    assign miss_bcd   = miss;
    assign game_over  = (state == OVER);
endmodule

// File: tb/tb_mole_game_core.sv
// Directed scoreboard bench for mole_game_core (SPAWN_TICKS=2 so all slots can fill).
module tb_mole_game_core;
    logic        clk = 1'b0;
    logic        rst_n, tick_en, start, time_up, hit_valid;
    logic [7:0]  rnd;
    logic [3:0]  hit_pos;
    logic [15:0] mole_map;
    logic [7:0]  score_bcd, miss_bcd;
    logic [1:0]  active_cnt;
    logic        game_over;

    typedef struct packed {
        logic [15:0] map;
        logic [7:0]  score;
        logic [7:0]  miss;
        logic [1:0]  cnt;
        logic        over;
    } obs_t;
    typedef struct {
        string tag;
        obs_t  v;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int passed = 0;

`ifdef MISS_PENALTY_EN
    localparam logic [7:0] PEN_SCORE = 8'h02;
`else
    localparam logic [7:0] PEN_SCORE = 8'h03;
`endif

    mole_game_core #(.GRID(16), .MAX_MOLES(3), .LIFE_TICKS(8), .SPAWN_TICKS(2), .SCORE_DIGITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .start(start), .time_up(time_up),
        .rnd(rnd), .hit_valid(hit_valid), .hit_pos(hit_pos), .mole_map(mole_map),
        .score_bcd(score_bcd), .miss_bcd(miss_bcd), .active_cnt(active_cnt), .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int n);
        int c;
        c = (n > 99) ? 99 : n;
        return {4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic cyc(input logic t, input logic st, input logic [7:0] r, input logic hv, input logic [3:0] hp);
        tick_en = t; start = st; rnd = r; hit_valid = hv; hit_pos = hp;
        @(posedge clk); #1;
        tick_en = 1'b0; start = 1'b0; hit_valid = 1'b0;
    endtask

    task automatic push(input string tag, input logic [15:0] m, input logic [7:0] s, input logic [7:0] ms,
                        input logic [1:0] c, input logic o);
        exp_t e;
        e.tag = tag;
        e.v   = '{map: m, score: s, miss: ms, cnt: c, over: o};
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        obs_t got;
        e   = sb.pop_front();
        got = {mole_map, score_bcd, miss_bcd, active_cnt, game_over};
        checks++;
        assert (got === e.v) passed++;
        else $error("FAIL %s: got map=%h score=%h miss=%h cnt=%0d over=%b, want map=%h score=%h miss=%h cnt=%0d over=%b",
                    e.tag, got.map, got.score, got.miss, got.cnt, got.over,
                    e.v.map, e.v.score, e.v.miss, e.v.cnt, e.v.over);
    endtask

    task automatic cyc_chk(input string tag, input logic t, input logic st, input logic [7:0] r, input logic hv,
                           input logic [3:0] hp, input logic [15:0] m, input logic [7:0] s, input logic [7:0] ms,
                           input logic [1:0] c, input logic o);
        push(tag, m, s, ms, c, o);
        cyc(t, st, r, hv, hp);
        pop_check();
    endtask

    initial begin
        int x;
        int n;
        rst_n = 1'b0; tick_en = 1'b0; start = 1'b0; time_up = 1'b0;
        rnd = 8'd0; hit_valid = 1'b0; hit_pos = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        push("reset", 16'h0, 8'h00, 8'h00, 2'd0, 1'b0);
        pop_check();
        rst_n = 1'b1;

        cyc_chk("start",        0, 1, 8'd0, 0, 4'd0, 16'h0000, 8'h00, 8'h00, 2'd0, 1'b0);
        cyc_chk("first_tick",   1, 0, 8'd5, 0, 4'd0, 16'h0000, 8'h00, 8'h00, 2'd0, 1'b0);
        cyc_chk("spawn5",       1, 0, 8'd5, 0, 4'd0, 16'h0020, 8'h00, 8'h00, 2'd1, 1'b0);
        cyc_chk("hit5",         0, 0, 8'd5, 1, 4'd5, 16'h0000, 8'h01, 8'h00, 2'd0, 1'b0);

        cyc(1, 0, 8'd7, 0, 4'd0);
        cyc_chk("spawn7",       1, 0, 8'd7, 0, 4'd0, 16'h0080, 8'h01, 8'h00, 2'd1, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1, 0, 8'd7, 0, 4'd0);
        cyc_chk("life_tick7",   1, 0, 8'd7, 0, 4'd0, 16'h0080, 8'h01, 8'h00, 2'd1, 1'b0);
        cyc_chk("expire_tick8", 1, 0, 8'd7, 0, 4'd0, 16'h0000, 8'h01, 8'h01, 2'd0, 1'b0);

        cyc(1, 0, 8'd1, 0, 4'd0);
        cyc_chk("fill1",        1, 0, 8'd1, 0, 4'd0, 16'h0002, 8'h01, 8'h01, 2'd1, 1'b0);
        cyc(1, 0, 8'd2, 0, 4'd0);
        cyc_chk("fill2",        1, 0, 8'd2, 0, 4'd0, 16'h0006, 8'h01, 8'h01, 2'd2, 1'b0);
        cyc(1, 0, 8'd3, 0, 4'd0);
        cyc_chk("fill3",        1, 0, 8'd3, 0, 4'd0, 16'h000E, 8'h01, 8'h01, 2'd3, 1'b0);
        cyc(1, 0, 8'd9, 0, 4'd0);
        cyc_chk("full_no_spawn",1, 0, 8'd9, 0, 4'd0, 16'h000E, 8'h01, 8'h01, 2'd3, 1'b0);
        cyc_chk("hit2",         0, 0, 8'd9, 1, 4'd2, 16'h000A, 8'h02, 8'h01, 2'd2, 1'b0);
        cyc(1, 0, 8'd3, 0, 4'd0);
        cyc_chk("occupied_no_spawn", 1, 0, 8'd3, 0, 4'd0, 16'h0008, 8'h02, 8'h02, 2'd1, 1'b0);

        cyc(1, 0, 8'd3, 0, 4'd0);
        cyc(1, 0, 8'd3, 0, 4'd0);
        cyc_chk("pre_expire",   1, 0, 8'd3, 0, 4'd0, 16'h0008, 8'h02, 8'h02, 2'd1, 1'b0);
        cyc_chk("hit_beats_expiry", 1, 0, 8'd3, 1, 4'd3, 16'h0000, 8'h03, 8'h02, 2'd0, 1'b0);
        cyc_chk("empty_press",  0, 0, 8'd3, 1, 4'd0, 16'h0000, PEN_SCORE, 8'h02, 2'd0, 1'b0);

        cyc(1, 0, 8'd4, 0, 4'd0);
        cyc_chk("spawn4",       1, 0, 8'd4, 0, 4'd0, 16'h0010, PEN_SCORE, 8'h02, 2'd1, 1'b0);
        time_up = 1'b1;
        cyc_chk("time_up",      0, 0, 8'd4, 0, 4'd0, 16'h0000, PEN_SCORE, 8'h02, 2'd0, 1'b1);
        cyc_chk("over_ignores", 1, 0, 8'd6, 1, 4'd4, 16'h0000, PEN_SCORE, 8'h02, 2'd0, 1'b1);
        cyc_chk("start_blocked",0, 1, 8'd6, 0, 4'd0, 16'h0000, PEN_SCORE, 8'h02, 2'd0, 1'b1);
        time_up = 1'b0;
        cyc_chk("restart",      0, 1, 8'd6, 0, 4'd0, 16'h0000, 8'h00, 8'h00, 2'd0, 1'b0);
        cyc_chk("empty_press_zero", 0, 0, 8'd6, 1, 4'd0, 16'h0000, 8'h00, 8'h00, 2'd0, 1'b0);

        n = 0;
        for (int k = 0; k < 100; k++) begin
            x = $urandom_range(0, 15);
            cyc(1, 0, 8'(x), 0, 4'd0);
            cyc_chk("spawn_rand", 1, 0, 8'(x), 0, 4'd0, 16'h1 << x, to_bcd(n), 8'h00, 2'd1, 1'b0);
            n++;
            cyc_chk("hit_rand",   0, 0, 8'(x), 1, 4'(x), 16'h0000, to_bcd(n), 8'h00, 2'd0, 1'b0);
        end

        cyc(1, 0, 8'd1, 0, 4'd0);
        cyc(1, 0, 8'd1, 0, 4'd0);
        cyc(1, 0, 8'd2, 0, 4'd0);
        cyc_chk("two_up",       1, 0, 8'd2, 0, 4'd0, 16'h0006, 8'h99, 8'h00, 2'd2, 1'b0);
        rst_n = 1'b0;
        #1;
        push("async_reset", 16'h0, 8'h00, 8'h00, 2'd0, 1'b0);
        pop_check();
        #1;
        rst_n = 1'b1;
        cyc(1, 0, 8'd1, 0, 4'd0);
        cyc_chk("idle_no_spawn",1, 0, 8'd1, 0, 4'd0, 16'h0000, 8'h00, 8'h00, 2'd0, 1'b0);
        cyc_chk("idle_hit",     0, 0, 8'd1, 1, 4'd1, 16'h0000, 8'h00, 8'h00, 2'd0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
